vga_frame_capture: RTL and testbench
====================================

# vga_frame_capture

Video-input writer that samples a raster pixel stream (strobe, HS, VS, blank, 8-bit grey pixel) and stores a rectangular window of one frame into the data memory as packed 32-bit words. It is the receiving/writing counterpart of the VGA output path, which reads the same memory and rasterises it. While `busy` is high it owns the memory write port. `done` serves as the hand-over select to the CPU side of the memory address mux.

## Interface
Parameters:
- `IMG_W`, 160: captured window width in pixels; must be a multiple of 4.
- `IMG_H`, 120: captured window height in lines.
- `X0`, 0: first captured active pixel in each line.
- `Y0`, 0: first captured active line.
- `BASE_ADDR`, 32'h0: memory address of the first word.
- `ADDR_STEP`, 4: address increment per word (byte addressing).

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that arms a capture.
- `pix_valid`  in  1: pixel strobe, at most one per 2 `clk` cycles.
- `hs_n`  in  1: horizontal sync, active low; sampled only with `pix_valid`.
- `vs_n`  in  1: vertical sync, active low; sampled only with `pix_valid`.
- `blank_n`  in  1: high during active video; sampled only with `pix_valid`.
- `pix`  in  8: grey pixel value.
- `mem_addr`  out  32: write address.
- `mem_wdata`  out  32: write data.
- `mem_we`  out  1: one-cycle write enable.
- `busy`  out  1: high in ARM and CAPTURE.
- `done`  out  1: level; high from end of capture until the next `start` or `rst`.
- `short_frame`  out  1: qualifies `done`; the frame ended before `IMG_H` lines were captured.

## Operation
- FSM states are IDLE → ARM → CAPTURE → DONE, and DONE → ARM on `start`.
  - IDLE/DONE + `start` → ARM; `done` and `short_frame` clear on the same edge.
  - ARM: wait for the `vs_n` falling edge (the previous sampled `vs_n` is 1 and the current is 0, both on strobes), then go to CAPTURE and clear `x`, `y` and the word counter.
  - CAPTURE → DONE when word `IMG_W*IMG_H/4 - 1` is written. `short_frame` stays 0.
  - CAPTURE → DONE with `short_frame=1` on the next `vs_n` falling edge when the frame is incomplete. A partially packed word is discarded.
- `start` is ignored in ARM and CAPTURE.
- Counters are updated only on `pix_valid`:
  - `x` counts strobes with `blank_n=1`.
  - On a `blank_n` 1→0 transition, `x` resets to 0 and `y` increments, but only if the line had at least one active pixel.
  - `y` saturates at `Y0+IMG_H`.
- A pixel is captured when `X0 ≤ x < X0+IMG_W` and `Y0 ≤ y < Y0+IMG_H`.
- Packing is little-endian: the first captured pixel goes in [7:0], the fourth in [31:24]. A 2-bit lane counter wraps 3→0.
- When the fourth lane fills, `mem_wdata` receives the word, `mem_addr = BASE_ADDR + word_idx*ADDR_STEP`, and `mem_we` pulses.
- Arithmetic: `word_idx` is 32-bit and the address sum is modulo 2^32. `x` and `y` are 12-bit and unsigned.
- `hs_n` is used only to re-synchronise: a `hs_n` falling edge while `blank_n=1` forces the `blank_n` end-of-line handling.

## Timing
- Reset values: all outputs are 0 (`mem_addr`, `mem_wdata`, `mem_we`, `busy`, `done`, `short_frame`), and the state is IDLE.
- Write latency: `mem_we` is high exactly one `clk` cycle, the cycle after the `clk` edge that samples the 4th pixel strobe. `mem_addr` and `mem_wdata` are valid in that cycle and held until the next write.
- `done` rises the cycle after the last `mem_we`.
- `busy` rises the cycle after `start`.
- There is no back-pressure; the memory must accept one write per cycle. The strobe spacing of ≥2 cycles guarantees writes never overlap.
- If `start` and a `vs_n` falling edge occur in the same cycle, the state moves to ARM only; capture begins at the following frame.
- `rst` mid-capture returns to IDLE on that edge, drops `mem_we` immediately, and issues no further writes.

## Structure
- Shared package `video_pkg`:
  - `typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_CAPTURE, CAP_DONE} cap_state_t`.
  - `PIX_W=8`, `WORD_W=32`, `PIX_PER_WORD=4`.
- Sub-module `sync_edge_det` produces registered previous values and 1→0 edge pulses for `vs_n`, `hs_n` and `blank_n`, gated by `pix_valid`. It is instantiated once and carries 3 channels.
- The remaining logic (FSM, counters, packer) lives in the top module.

## Test plan
All scenarios use `IMG_W=8`, `IMG_H=2`, `X0=2`, `Y0=1`, `BASE_ADDR=32'h100`, `ADDR_STEP=4`, and pixel value = `x + 16*y`.

1. `start`, then a full frame with a strobe every 2 cycles → exactly 4 writes:
   - 32'h15141312 @ 0x100
   - 32'h19181716 @ 0x104
   - 32'h25242322 @ 0x108
   - 32'h29282726 @ 0x10C
   
   Then `done=1`, `short_frame=0`, `busy=0`.
2. No `start`, same frame → no `mem_we`, `busy=0`.
3. `start`, then `vs_n` falls again after line y=1 only → 2 writes (0x100, 0x104), then `done=1`, `short_frame=1`.
4. Assert `rst` after the first write → `mem_we` stays 0 from that edge on and all outputs are 0. Issue a new `start` and a full frame → the write sequence restarts at 0x100.
5. A second `start` pulse during CAPTURE → ignored; still exactly 4 writes.
6. Strobe every cycle with `hs_n` pulses but no active line (`blank_n=0`) → `y` does not increment and no writes occur. The state remains CAPTURE until the next `vs_n` edge, which ends with `short_frame=1`.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video types and constants for the capture and output paths.
package video_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ARM,
        CAP_CAPTURE,
        CAP_DONE
    } cap_state_t;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

endpackage

// File: rtl/vga_frame_capture_sync_edge_det.sv
// Strobe-gated sampling of sync/blank levels with 1->0 edge pulses.
module sync_edge_det #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_valid,
    input  logic [N-1:0] sig,
    output logic [N-1:0] fall
);

    logic [N-1:0] prev;

    // Reset low so a level already low after reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (pix_valid) begin
            prev <= sig;
        end
    end

    assign fall = {N{pix_valid}} & prev & ~sig;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures a window of one raster frame into memory as packed 32-bit words.
import video_pkg::*;

module vga_frame_capture #(
    parameter int          IMG_W     = 160,
    parameter int          IMG_H     = 120,
    parameter int          X0        = 0,
    parameter int          Y0        = 0,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              hs_n,
    input  logic              vs_n,
    input  logic              blank_n,
    input  logic [PIX_W-1:0]  pix,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              short_frame
);

    localparam logic [11:0] X_LO      = 12'(X0);
    localparam logic [11:0] X_HI      = 12'(X0 + IMG_W);
    localparam logic [11:0] Y_LO      = 12'(Y0);
    localparam logic [11:0] Y_HI      = 12'(Y0 + IMG_H);
    localparam logic [31:0] LAST_WORD = 32'(IMG_W * IMG_H / PIX_PER_WORD - 1);
    localparam logic [31:0] STEP      = 32'(ADDR_STEP);

    localparam int VS = 0;
    localparam int HS = 1;
    localparam int BL = 2;

    logic [2:0]        fall;
    cap_state_t        state;
    logic [11:0]       x;
    logic [11:0]       y;
    logic [31:0]       word_idx;
    logic [1:0]        lane;
    logic [WORD_W-1:0] pack;
    logic              fin;
    logic              eol;
    logic              in_win;

    sync_edge_det #(.N(3)) u_edge (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .sig       ({blank_n, hs_n, vs_n}),
        .fall      (fall)
    );

    // An hs_n edge inside active video closes the line early.
    assign eol    = fall[BL] | (fall[HS] & blank_n);
    assign in_win = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CAP_IDLE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_frame <= 1'b0;
            x           <= '0;
            y           <= '0;
            word_idx    <= '0;
            lane        <= '0;
            pack        <= '0;
            fin         <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                CAP_IDLE, CAP_DONE: begin
                    if (start) begin
                        state       <= CAP_ARM;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        short_frame <= 1'b0;
                    end
                end
                CAP_ARM: begin
                    if (fall[VS]) begin
                        state    <= CAP_CAPTURE;
                        x        <= '0;
                        y        <= '0;
                        word_idx <= '0;
                        lane     <= '0;
                    end
                end
                CAP_CAPTURE: begin
                    if (fin) begin
                        state <= CAP_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fin   <= 1'b0;
                    end else if (fall[VS]) begin
                        state       <= CAP_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        short_frame <= 1'b1;
                    end else if (pix_valid) begin
                        if (eol) begin
                            if (x != 12'd0) begin
                                x <= '0;
                                if (y < Y_HI) y <= y + 12'd1;
                            end
                        end else if (blank_n) begin
                            x <= x + 12'd1;
                            if (in_win) begin
                                lane <= lane + 2'd1;
                                if (lane == 2'd3) begin
                                    mem_we    <= 1'b1;
                                    mem_wdata <= {pix, pack[23:0]};
                                    mem_addr  <= BASE_ADDR + word_idx * STEP;
                                    word_idx  <= word_idx + 32'd1;
                                    fin       <= (word_idx == LAST_WORD);
                                end else begin
                                    pack[{lane, 3'b000} +: PIX_W] <= pix;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomised and directed checks of vga_frame_capture against a frame-level model.
module tb_vga_frame_capture;

    localparam int          W    = 8;
    localparam int          H    = 2;
    localparam int          XO   = 2;
    localparam int          YO   = 1;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          STEP = 4;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_CAP  = 2;
    localparam int P_DONE = 3;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        pix_valid = 0;
    logic        hs_n = 1;
    logic        vs_n = 1;
    logic        blank_n = 0;
    logic [7:0]  pix = 0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        short_frame;

    vga_frame_capture #(
        .IMG_W(W), .IMG_H(H), .X0(XO), .Y0(YO),
        .BASE_ADDR(BASE), .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n), .pix(pix),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Expected outputs after the next rising edge.
    logic        e_we = 0, e_busy = 0, e_done = 0, e_short = 0;
    logic [31:0] e_addr = 0, e_data = 0;
    int          ph = P_IDLE;
    int          mx = 0, my = 0, nw = 0;
    byte unsigned q[$];
    bit          pvs = 0, phs = 0, pbl = 0, fin = 0;
    logic [63:0] wlog[$];

    bit rnd_pix = 0;
    int gap_lo = 1;
    int gap_hi = 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        nvec++;
        if ({mem_we, busy, done, short_frame} !== {e_we, e_busy, e_done, e_short} ||
            mem_addr !== e_addr || mem_wdata !== e_data) begin
            nerr++;
            $display("FAIL cycle@%0t: we/busy/done/short=%b%b%b%b addr=%h data=%h expected %b%b%b%b addr=%h data=%h",
                     $time, mem_we, busy, done, short_frame, mem_addr, mem_wdata,
                     e_we, e_busy, e_done, e_short, e_addr, e_data);
        end
        if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic model_step();
        bit vf, hf, bf;
        e_we = 0;
        if (rst) begin
            e_busy = 0; e_done = 0; e_short = 0; e_addr = 0; e_data = 0;
            ph = P_IDLE; fin = 0; pvs = 0; phs = 0; pbl = 0;
            q.delete();
            return;
        end
        vf = pix_valid && pvs && !vs_n;
        hf = pix_valid && phs && !hs_n;
        bf = pix_valid && pbl && !blank_n;
        if (ph == P_CAP && fin) begin
            ph = P_DONE; e_busy = 0; e_done = 1; fin = 0;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (start) begin
                    ph = P_ARM; e_busy = 1; e_done = 0; e_short = 0;
                end
                P_ARM: if (vf) begin
                    ph = P_CAP; mx = 0; my = 0; nw = 0; q.delete();
                end
                default: if (vf) begin
                    ph = P_DONE; e_busy = 0; e_done = 1; e_short = 1;
                end else if (pix_valid) begin
                    if (bf || (hf && blank_n)) begin
                        if (mx != 0) begin
                            mx = 0;
                            my = (my + 1 > YO + H) ? YO + H : my + 1;
                        end
                    end else if (blank_n) begin
                        if (mx >= XO && mx < XO + W && my >= YO && my < YO + H) begin
                            q.push_back(pix);
                            if (q.size() == 4) begin
                                e_we = 1;
                                e_data = {q[3], q[2], q[1], q[0]};
                                e_addr = BASE + 32'(nw * STEP);
                                nw++;
                                q.delete();
                                if (nw == W * H / 4) fin = 1;
                            end
                        end
                        mx++;
                    end
                end
            endcase
        end
        if (pix_valid) begin
            pvs = vs_n; phs = hs_n; pbl = blank_n;
        end
    endtask

    task automatic tick(bit st, bit pv, bit h, bit v, bit b, logic [7:0] p);
        @(negedge clk);
        start = st; pix_valid = pv; hs_n = h; vs_n = v; blank_n = b; pix = p;
        model_step();
    endtask

    task automatic strobe(bit h, bit v, bit b, logic [7:0] p);
        int g;
        g = $urandom_range(gap_hi, gap_lo);
        tick(0, 1, h, v, b, p);
        repeat (g) tick(0, 0, h, v, b, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; start = 0; pix_valid = 0;
        model_step();
        @(negedge clk);
        rst = 0;
        model_step();
    endtask

    task automatic pulse_start();
        tick(1, 0, 1, 1, 0, 8'h00);
        tick(0, 0, 1, 1, 0, 8'h00);
    endtask

    task automatic vsync();
        strobe(1, 1, 0, 0);
        strobe(1, 0, 0, 0);
        strobe(1, 0, 0, 0);
        strobe(1, 1, 0, 0);
    endtask

    task automatic active(int y, int xa, int xb);
        bit hg;
        logic [7:0] p;
        for (int xx = xa; xx < xb; xx++) begin
            hg = rnd_pix && ($urandom_range(0, 15) == 0);
            p = rnd_pix ? 8'($urandom) : 8'(xx + 16 * y);
            strobe(!hg, 1, 1, p);
        end
    endtask

    task automatic hblank();
        strobe(1, 1, 0, 0);
        strobe(1, 1, 0, 0);
        strobe(0, 1, 0, 0);
        strobe(1, 1, 0, 0);
    endtask

    task automatic frame(int nl, int nact);
        vsync();
        for (int yy = 0; yy < nl; yy++) begin
            hblank();
            active(yy, 0, nact);
        end
        strobe(1, 1, 0, 0);
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 0, 1, 1, 0, 0);
    endtask

    initial begin
        do_reset();
        check("reset_addr", mem_addr, 32'h0);
        check("reset_flags", {28'h0, mem_we, busy, done, short_frame}, 32'h0);

        // 1: full frame
        wlog.delete();
        pulse_start();
        check("busy_after_start", {31'h0, busy}, 32'h1);
        frame(4, 12);
        idle(3);
        check("s1_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("s1_w0", wlog[0][31:0], 32'h15141312);
            check("s1_a0", wlog[0][63:32], 32'h100);
            check("s1_w1", wlog[1][31:0], 32'h19181716);
            check("s1_a1", wlog[1][63:32], 32'h104);
            check("s1_w2", wlog[2][31:0], 32'h25242322);
            check("s1_a2", wlog[2][63:32], 32'h108);
            check("s1_w3", wlog[3][31:0], 32'h29282726);
            check("s1_a3", wlog[3][63:32], 32'h10C);
        end
        check("s1_flags", {29'h0, busy, done, short_frame}, 32'b010);

        // 2: no start
        do_reset();
        wlog.delete();
        frame(4, 12);
        idle(3);
        check("s2_nwrites", wlog.size(), 0);
        check("s2_busy", {31'h0, busy}, 32'h0);

        // 3: frame cut short by vsync
        wlog.delete();
        pulse_start();
        frame(2, 12);
        vsync();
        idle(2);
        check("s3_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) check("s3_a1", wlog[1][63:32], 32'h104);
        check("s3_flags", {29'h0, busy, done, short_frame}, 32'b011);

        // 4: reset after first write
        wlog.delete();
        pulse_start();
        vsync();
        hblank();
        active(0, 0, 12);
        hblank();
        active(1, 0, 6);
        check("s4_first", wlog.size(), 1);
        do_reset();
        check("s4_rst_flags", {28'h0, mem_we, busy, done, short_frame}, 32'h0);
        check("s4_rst_data", mem_wdata, 32'h0);
        wlog.delete();
        active(1, 6, 12);
        hblank();
        active(2, 0, 12);
        idle(2);
        check("s4_no_wr", wlog.size(), 0);
        pulse_start();
        frame(4, 12);
        idle(3);
        check("s4_nwrites", wlog.size(), 4);
        if (wlog.size() > 0) check("s4_restart", wlog[0][63:32], 32'h100);

        // 5: start during capture ignored
        wlog.delete();
        pulse_start();
        vsync();
        hblank();
        active(0, 0, 12);
        pulse_start();
        hblank();
        active(1, 0, 12);
        hblank();
        active(2, 0, 12);
        strobe(1, 1, 0, 0);
        idle(3);
        check("s5_nwrites", wlog.size(), 4);
        check("s5_flags", {29'h0, busy, done, short_frame}, 32'b010);

        // 6: strobe every cycle, no active video
        wlog.delete();
        pulse_start();
        vsync();
        gap_lo = 0; gap_hi = 0;
        for (int i = 0; i < 20; i++) strobe((i % 5) != 2, 1, 0, 0);
        check("s6_busy", {31'h0, busy}, 32'h1);
        vsync();
        idle(2);
        gap_lo = 1; gap_hi = 1;
        check("s6_nwrites", wlog.size(), 0);
        check("s6_flags", {29'h0, busy, done, short_frame}, 32'b011);

        // Randomised frames against the model
        do_reset();
        rnd_pix = 1;
        gap_lo = 1; gap_hi = 3;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) != 0) pulse_start();
            frame($urandom_range(1, 4), $urandom_range(6, 14));
            if ($urandom_range(0, 1) == 1) vsync();
            idle(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
